// File: rtl/bfsh_pkg.sv
// Shared definitions for the Blowfish host controller.
//   bfsh_state_e       : controller FSM states
//   bfsh_blk_t         : 64-bit key/data block
//   KEY_GAP_CYCLES     : idle cycles after the key strobe, before initializing is watched
//   INIT_STABLE_CYCLES : consecutive samples of core_initializing=0 needed to call the key ready
//   cnt_width()        : counter width that can hold the values 0..n-1 (minimum 1 bit)
package bfsh_pkg;

    typedef logic [63:0] bfsh_blk_t;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StKeyPulse = 4'd1,
        StKeyGap   = 4'd2,
        StKeyWait  = 4'd3,
        StReady    = 4'd4,
        StPtPulse  = 4'd5,
        StPtStart  = 4'd6,
        StPtRun    = 4'd7,
        StResult   = 4'd8
    } bfsh_state_e;

    localparam int unsigned KEY_GAP_CYCLES     = 2;
    localparam int unsigned INIT_STABLE_CYCLES = 2;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bfsh_host_ctrl.sv
// Host-side sequencer for a Blowfish core (BFSH_Core), instantiated beside it at the top.
// Takes keys and blocks from a valid/ready host interface, strobes them into the core,
// waits for the core's handshake levels and returns the result on a valid/ready port.
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   key_valid/key/key_ready       host key offer and acceptance
//   blk_valid/blk_data/blk_enc    host block offer (blk_enc: 1 = encrypt, 0 = decrypt)
//   blk_ready                     block accepted this cycle
//   res_valid/res_data/res_ready  result handshake
//   keyed                         core holds a valid key schedule
//   err                           one-cycle timeout pulse
//   core_*                        strobes/data to the core and its status/result back
//
// Build option
//   BFSH_HOST_TIMEOUT_EN : adds a per-state wait counter; a wait reaching TIMEOUT_CYCLES
//                          (or a second missed core start) pulses err, drops keyed and
//                          returns to idle. Without it err is tied low and waits are unbounded.
module bfsh_host_ctrl
    import bfsh_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned START_WAIT     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [63:0] key,
    output logic        key_ready,
    input  logic        blk_valid,
    input  logic [63:0] blk_data,
    input  logic        blk_enc,
    output logic        blk_ready,
    output logic        res_valid,
    output logic [63:0] res_data,
    input  logic        res_ready,
    output logic        keyed,
    output logic        err,
    output logic        core_en_key,
    output logic [63:0] core_key,
    output logic        core_en_pt,
    output logic [63:0] core_pt,
    output logic        core_en_enc_dec,
    input  logic        core_initializing,
    input  logic        core_busy,
    input  logic [63:0] core_ct
);

    localparam int unsigned GapW = cnt_width(KEY_GAP_CYCLES);
    localparam int unsigned StbW = cnt_width(INIT_STABLE_CYCLES);
    localparam int unsigned SwW  = cnt_width(START_WAIT);

    bfsh_state_e     state_q, state_d;
    bfsh_blk_t       core_key_q, core_key_d;
    bfsh_blk_t       core_pt_q, core_pt_d;
    logic            enc_q, enc_d;
    bfsh_blk_t       res_data_q, res_data_d;
    logic            res_valid_q, res_valid_d;
    logic            keyed_q, keyed_d;
    // Set once the current block has had its single start retry.
    logic            retried_q, retried_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic [StbW-1:0] stable_cnt_q, stable_cnt_d;
    logic [SwW-1:0]  start_cnt_q, start_cnt_d;
    logic            key_ready_c;
    logic            blk_ready_c;

`ifdef BFSH_HOST_TIMEOUT_EN
    localparam int unsigned ToW = cnt_width(TIMEOUT_CYCLES);

    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           start_miss;
    logic           to_count;
    logic           to_hit;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        core_key_d   = core_key_q;
        core_pt_d    = core_pt_q;
        enc_d        = enc_q;
        res_data_d   = res_data_q;
        res_valid_d  = res_valid_q;
        keyed_d      = keyed_q;
        retried_d    = retried_q;
        // Phase counters restart from zero whenever their phase is not running.
        gap_cnt_d    = '0;
        stable_cnt_d = '0;
        start_cnt_d  = '0;
        key_ready_c  = 1'b0;
        blk_ready_c  = 1'b0;
`ifdef BFSH_HOST_TIMEOUT_EN
        start_miss   = 1'b0;
`endif

        case (state_q)
            StIdle, StReady: begin
                // A new key wins over a block; blocks need an established key schedule.
                if (key_valid) begin
                    key_ready_c = 1'b1;
                    core_key_d  = key;
                    keyed_d     = 1'b0;
                    state_d     = StKeyPulse;
                end else if ((state_q == StReady) && blk_valid && !res_valid_q) begin
                    blk_ready_c = 1'b1;
                    core_pt_d   = blk_data;
                    enc_d       = blk_enc;
                    retried_d   = 1'b0;
                    state_d     = StPtPulse;
                end
            end

            StKeyPulse: state_d = StKeyGap;

            // The core only starts on the falling edge of its key strobe, so give it time
            // to raise core_initializing before that level is trusted.
            StKeyGap: begin
                if (gap_cnt_q == GapW'(KEY_GAP_CYCLES - 1)) begin
                    state_d = StKeyWait;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end

            StKeyWait: begin
                if (!core_initializing) begin
                    if (stable_cnt_q == StbW'(INIT_STABLE_CYCLES - 1)) begin
                        keyed_d = 1'b1;
                        state_d = StReady;
                    end else begin
                        stable_cnt_d = stable_cnt_q + StbW'(1);
                    end
                end
            end

            StPtPulse: state_d = StPtStart;

            StPtStart: begin
                if (core_busy) begin
                    state_d = StPtRun;
                end else if (start_cnt_q == SwW'(START_WAIT - 1)) begin
                    if (!retried_q) begin
                        retried_d = 1'b1;
                        state_d   = StPtPulse;
                    end else begin
                        // Second miss: hold here (saturated) until the core shows up.
`ifdef BFSH_HOST_TIMEOUT_EN
                        start_miss  = 1'b1;
`endif
                        start_cnt_d = start_cnt_q;
                    end
                end else begin
                    start_cnt_d = start_cnt_q + SwW'(1);
                end
            end

            StPtRun: begin
                if (!core_busy) begin
                    res_data_d  = core_ct;
                    res_valid_d = 1'b1;
                    state_d     = StResult;
                end
            end

            StResult: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StReady;
                end
            end

            default: state_d = StIdle;
        endcase

`ifdef BFSH_HOST_TIMEOUT_EN
        to_count = (state_q == StKeyWait) || (state_q == StPtStart) || (state_q == StPtRun);
        // Only a wait that is still pending can expire; leaving the state this cycle wins.
        to_hit   = start_miss ||
                   (to_count && (state_d == state_q) &&
                    (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)));
        if (to_hit) begin
            keyed_d = 1'b0;
            state_d = StIdle;
        end
        err      = to_hit;
        to_cnt_d = ((state_d != state_q) || !to_count) ? '0 : to_cnt_q + ToW'(1);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            core_key_q   <= '0;
            core_pt_q    <= '0;
            enc_q        <= 1'b0;
            res_data_q   <= '0;
            res_valid_q  <= 1'b0;
            keyed_q      <= 1'b0;
            retried_q    <= 1'b0;
            gap_cnt_q    <= '0;
            stable_cnt_q <= '0;
            start_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            core_key_q   <= core_key_d;
            core_pt_q    <= core_pt_d;
            enc_q        <= enc_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            keyed_q      <= keyed_d;
            retried_q    <= retried_d;
            gap_cnt_q    <= gap_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            start_cnt_q  <= start_cnt_d;
        end
    end

`ifdef BFSH_HOST_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    // Nothing is accepted while reset is held, so do not advertise readiness then.
    assign key_ready       = key_ready_c & ~rst;
    assign blk_ready       = blk_ready_c;
    assign res_valid       = res_valid_q;
    assign res_data        = res_data_q;
    assign keyed           = keyed_q;
    assign core_en_key     = (state_q == StKeyPulse);
    assign core_en_pt      = (state_q == StPtPulse);
    assign core_key        = core_key_q;
    assign core_pt         = core_pt_q;
    assign core_en_enc_dec = enc_q;

endmodule

// File: doc/bfsh_host_ctrl.md
BFSH_HOST_CTRL -- requirements
Module: bfsh_host_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 4096: maximum wait cycles per core phase; used only under BFSH_HOST_TIMEOUT_EN.
REQ-002 Parameter START_WAIT, 4: cycles allowed for core_busy to rise after a plaintext pulse.
REQ-003 Ports, clock and reset first:
- clk  in  1  sole clock; all logic on posedge clk.
- rst  in  1  reset; asynchronous and active-high.
- key_valid  in  1  host offers a new key.
- key  in  64  key value.
- key_ready  out  1  key accepted this cycle.
- blk_valid  in  1  host offers a data block.
- blk_data  in  64  plaintext or ciphertext block.
- blk_enc  in  1  1 = encrypt, 0 = decrypt.
- blk_ready  out  1  block accepted this cycle.
- res_valid  out  1  result available.
- res_data  out  64  result block.
- res_ready  in  1  host consumes the result.
- keyed  out  1  core holds a valid key schedule.
- err  out  1  one-cycle timeout pulse.
- core_en_key  out  1  key strobe to the core.
- core_key  out  64  key to the core.
- core_en_pt  out  1  block strobe to the core.
- core_pt  out  64  block to the core.
- core_en_enc_dec  out  1  mode to the core.
- core_initializing  in  1  core is running key expansion.
- core_busy  in  1  core is processing a block.
- core_ct  in  64  core result.

Function
REQ-004 The block SHALL use these FSM states: IDLE, KEY_PULSE, KEY_GAP, KEY_WAIT, READY, PT_PULSE, PT_START, PT_RUN, RESULT.
REQ-005 In IDLE or READY, when key_valid=1, the block SHALL:
- assert key_ready for one cycle;
- register key into core_key;
- clear keyed;
- go to KEY_PULSE.
REQ-006 KEY_PULSE SHALL drive core_en_key=1 for exactly one cycle, then go to KEY_GAP with core_en_key=0. The core starts on the falling edge of core_en_key.
REQ-007 KEY_GAP SHALL last 2 cycles, then go to KEY_WAIT.
REQ-008 KEY_WAIT SHALL wait for core_initializing=0 sampled on 2 consecutive cycles, then set keyed=1 and go to READY.
REQ-009 In READY with key_valid=0, blk_valid=1 and res_valid=0, the block SHALL:
- assert blk_ready for one cycle;
- register blk_data into core_pt and blk_enc into core_en_enc_dec;
- go to PT_PULSE.
REQ-010 key_valid SHALL take priority over blk_valid in READY. In IDLE, blk_ready SHALL stay 0.
REQ-011 PT_PULSE SHALL drive core_en_pt=1 for exactly one cycle and SHALL hold core_key stable. core_en_key SHALL be 0 whenever core_en_pt=1.
REQ-012 PT_START SHALL wait up to START_WAIT cycles for core_busy=1, then go to PT_RUN.
REQ-013 If core_busy does not rise within START_WAIT cycles, PT_START SHALL re-issue PT_PULSE once. A second miss SHALL be treated as a timeout.
REQ-014 PT_RUN SHALL wait for core_busy=0. In that same cycle it SHALL register core_ct into res_data, set res_valid=1, and go to RESULT.
REQ-015 RESULT SHALL hold res_valid and res_data stable until res_ready=1, then go to READY. Latency from blk_ready to res_valid is core latency + 2 cycles.
REQ-016 core_pt, core_key and core_en_enc_dec SHALL stay stable from their strobe until the next accepted key or block.
REQ-017 key_valid during PT_* or RESULT SHALL not be accepted until the FSM returns to READY.

Reset
REQ-018 On rst=1, asynchronously:
- state = IDLE;
- all outputs = 0, including core_key, core_pt and res_data;
- keyed = 0;
- timeout counter = 0.
REQ-019 Reset mid-operation SHALL abandon any in-flight block and discard any pending result. A new key is required before blocks are accepted.

Configuration
REQ-020 With BFSH_HOST_TIMEOUT_EN defined, a counter SHALL clear on each state entry and increment in KEY_WAIT, PT_START and PT_RUN.
REQ-021 With BFSH_HOST_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES, the block SHALL pulse err for one cycle, clear keyed, and go to IDLE.
REQ-022 With BFSH_HOST_TIMEOUT_EN undefined, the block SHALL have no counter, SHALL tie err to 0, and SHALL wait indefinitely (REQ-013 re-issue still applies).

Structure
REQ-023 The shared package bfsh_pkg SHALL hold:
- the state enum;
- the 64-bit block typedef;
- the constants KEY_GAP_CYCLES=2 and INIT_STABLE_CYCLES=2.
REQ-024 bfsh_host_ctrl SHALL be a single module with no sub-modules, and SHALL instantiate beside BFSH_Core at the top level.

Verification
REQ-025 Bench against the real core or its behavioural model:
- Key 64'h0, then encrypt block 64'h0 -> res_data = 64'h4EF997456198DD78; core_en_key and core_en_pt each high exactly 1 cycle.
- Decrypt 64'h4EF997456198DD78 with the same key -> res_data = 64'h0.
- Hold res_ready=0 for 20 cycles after a result -> res_valid and res_data stable, blk_ready=0, no core_en_pt pulse.
- key_valid and blk_valid asserted together in READY -> key accepted first, block accepted only after keyed=1.
- Pulse rst during PT_RUN -> all outputs 0 next cycle; blk_ready stays 0 until a new key completes.
- With BFSH_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=64, hold core_busy=1 -> err pulses once at cycle 64 of PT_RUN, keyed=0, state IDLE.
